os_fifo: RTL and testbench

Output-storage FIFO that buffers 49-bit LCT output records produced in the clk domain by the trigger logic and presents them to the JTAG TAP as the 51-bit OS word, read-ahead style. Each OSread capture in the TAP pulses `os_rd` (tck domain). This block synchronises the pulse and pops the next record into the presented register. The presented word therefore changes only after the TAP has already sampled it, which removes the cross-domain data hazard on `os_data`.

---
 rtl/alct_pkg.sv | 16 +
 rtl/os_fifo_pulse_sync.sv | 25 ++
 rtl/os_fifo.sv | 86 ++++++++
 tb/tb_os_fifo.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alct_pkg.sv
// Shared constants for the LCT output-storage path between trigger logic and the TAP.
package alct_pkg;

  localparam int OS_W         = 51;
  localparam int OS_VALID_BIT = 50;
  localparam int OS_OVF_BIT   = 49;
  localparam int OS_DW        = 49;
  localparam int OS_DEPTH     = 16;

  typedef struct packed {
    logic              valid;
    logic              ovf;
    logic [OS_DW-1:0]  payload;
  } os_word_t;

endpackage

// File: rtl/os_fifo_pulse_sync.sv
// Three-flop synchroniser with rising-edge detect; one clk pulse per din rising edge.
module pulse_sync (
  input  logic clk,
  input  logic hard_rst,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge hard_rst) begin
    if (!hard_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/os_fifo.sv
// Output-storage FIFO: buffers LCT records in clk and presents them read-ahead to the TAP
// as {valid, ovf, payload}, popping the next record after each synchronised OSread.
module os_fifo
  import alct_pkg::*;
#(
  parameter int DEPTH = OS_DEPTH,
  parameter int DW    = OS_DW
) (
  input  logic                     clk,
  input  logic                     hard_rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     os_rd,
  output logic [DW+1:0]            os_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_nxt;
  logic          pop, do_wr, do_rd;

  pulse_sync u_rd_sync (
    .clk      (clk),
    .hard_rst (hard_rst),
    .din      (os_rd),
    .pulse    (pop)
  );

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // full/empty are taken from pre-cycle state, so a pop never frees room for a same-cycle write
  assign do_wr = wr_en & ~full & ~clr;
  assign do_rd = pop & ~empty & ~clr;

  always_comb begin
    cnt_nxt = count;
    if (do_wr && !do_rd)
      cnt_nxt = count + 1'b1;
    else if (!do_wr && do_rd)
      cnt_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge hard_rst) begin
    if (!hard_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      os_data  <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= cnt_nxt;
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      if (pop)
        os_data <= empty ? {1'b0, overflow, {DW{1'b0}}}
                         : {1'b1, overflow, mem[rd_ptr]};
      // a drop in the same cycle as a pop must stay visible to software
      if (wr_en && full)
        overflow <= 1'b1;
      else if (pop)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_os_fifo.sv
// Directed self-checking bench for os_fifo with hand-computed expected words.
module tb_os_fifo;

  logic        clk = 1'b0;
  logic        hard_rst = 1'b0;
  logic        clr = 1'b0;
  logic        wr_en = 1'b0;
  logic [48:0] wr_data = '0;
  logic        os_rd = 1'b0;
  logic [50:0] os_data;
  logic [4:0]  count;
  logic        full, empty, overflow;

  int checks = 0;
  int errors = 0;

  os_fifo #(.DEPTH(16), .DW(49)) dut (
    .clk      (clk),
    .hard_rst (hard_rst),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .os_rd    (os_rd),
    .os_data  (os_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [50:0] w(input logic v, input logic o, input logic [48:0] p);
    return {v, o, p};
  endfunction

  task automatic write_n(input int n, input logic [48:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = base + 49'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // os_rd high 4 clk, low 3 clk; optional write/clr lands in the cycle the pop takes effect
  task automatic pop_with(input logic do_wr, input logic [48:0] d, input logic do_clr);
    @(negedge clk);
    os_rd = 1'b1;
    repeat (2) @(negedge clk);
    wr_en = do_wr;
    wr_data = d;
    clr = do_clr;
    @(negedge clk);
    wr_en = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    os_rd = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (os_data !== '0) begin errors++; $display("FAIL rst_os_data got %h want 0", os_data); end
    checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL rst_flags got cnt=%0d e=%b f=%b o=%b want 0 1 0 0", count, empty, full, overflow);
    end
    hard_rst = 1'b1;
    write_n(5, 49'h100);
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL pre_rst_count got %0d want 5", count); end
    @(negedge clk);
    #2 hard_rst = 1'b0;
    #1;
    checks++; if (os_data !== '0 || count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL mid_rst got os=%h cnt=%0d e=%b o=%b want 0 0 1 0", os_data, count, empty, overflow);
    end
    @(negedge clk);
    hard_rst = 1'b1;
    pop_with(1'b0, '0, 1'b0);
    checks++; if (os_data !== w(1'b0, 1'b0, '0)) begin errors++; $display("FAIL rst_first_read got %h want 0", os_data); end
  endtask

  task automatic test_basic();
    logic [48:0] exp_p [4];
    logic        exp_v [4];
    logic [4:0]  exp_c [4];
    exp_p = '{49'h1A, 49'h2B, 49'h3C, 49'h0};
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_c = '{5'd2, 5'd1, 5'd0, 5'd0};
    @(negedge clk); wr_en = 1'b1; wr_data = 49'h1A;
    @(negedge clk); wr_data = 49'h2B;
    @(negedge clk); wr_data = 49'h3C;
    @(negedge clk); wr_en = 1'b0;
    checks++; if (count !== 5'd3 || empty !== 1'b0) begin errors++; $display("FAIL basic_count got %0d want 3", count); end
    for (int i = 0; i < 4; i++) begin
      pop_with(1'b0, '0, 1'b0);
      checks++; if (os_data !== w(exp_v[i], 1'b0, exp_p[i])) begin
        errors++; $display("FAIL basic_pop%0d got %h want %h", i, os_data, w(exp_v[i], 1'b0, exp_p[i]));
      end
      checks++; if (count !== exp_c[i]) begin errors++; $display("FAIL basic_cnt%0d got %0d want %0d", i, count, exp_c[i]); end
    end
  endtask

  task automatic test_overflow_and_clr();
    write_n(17, 49'h200);
    checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_fill got cnt=%0d f=%b o=%b want 16 1 1", count, full, overflow);
    end
    pop_with(1'b0, '0, 1'b0);
    checks++; if (os_data !== w(1'b1, 1'b1, 49'h200)) begin errors++; $display("FAIL ovf_pop got %h want %h", os_data, w(1'b1, 1'b1, 49'h200)); end
    checks++; if (overflow !== 1'b0 || count !== 5'd15) begin errors++; $display("FAIL ovf_clear got o=%b cnt=%0d want 0 15", overflow, count); end
    write_n(1, 49'h2FF);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL refill got full=%b want 1", full); end
    // full FIFO: same-cycle write is dropped, pop proceeds, new overflow survives
    pop_with(1'b1, 49'h777, 1'b0);
    checks++; if (os_data !== w(1'b1, 1'b0, 49'h201)) begin errors++; $display("FAIL full_pop got %h want %h", os_data, w(1'b1, 1'b0, 49'h201)); end
    checks++; if (count !== 5'd15 || overflow !== 1'b1) begin errors++; $display("FAIL full_pop_state got cnt=%0d o=%b want 15 1", count, overflow); end
    pop_with(1'b0, '0, 1'b1);
    checks++; if (count !== 5'd0 || overflow !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL clr_state got cnt=%0d o=%b e=%b want 0 0 1", count, overflow, empty);
    end
    checks++; if (os_data !== w(1'b1, 1'b0, 49'h201)) begin errors++; $display("FAIL clr_os_data got %h want %h", os_data, w(1'b1, 1'b0, 49'h201)); end
    pop_with(1'b0, '0, 1'b0);
    checks++; if (os_data !== w(1'b0, 1'b0, '0)) begin errors++; $display("FAIL post_clr_pop got %h want 0", os_data); end
  endtask

  task automatic test_empty_pop_write();
    pop_with(1'b1, 49'h55, 1'b0);
    checks++; if (os_data !== w(1'b0, 1'b0, '0)) begin errors++; $display("FAIL epw_os got %h want 0", os_data); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL epw_cnt got %0d want 1", count); end
    pop_with(1'b0, '0, 1'b0);
    checks++; if (os_data !== w(1'b1, 1'b0, 49'h55)) begin errors++; $display("FAIL epw_next got %h want %h", os_data, w(1'b1, 1'b0, 49'h55)); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL epw_cnt2 got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    logic [48:0] rec;
    write_n(2, 49'h1000);
    for (int i = 0; i < 38; i++) begin
      pop_with(1'b1, 49'h1000 + 49'(i + 2), 1'b0);
      rec = 49'h1000 + 49'(i);
      checks++; if (os_data !== w(1'b1, 1'b0, rec)) begin errors++; $display("FAIL wrap_pop%0d got %h want %h", i, os_data, w(1'b1, 1'b0, rec)); end
      checks++; if (count !== 5'd2 || full !== 1'b0) begin errors++; $display("FAIL wrap_cnt%0d got cnt=%0d f=%b want 2 0", i, count, full); end
    end
    for (int i = 38; i < 40; i++) begin
      pop_with(1'b0, '0, 1'b0);
      rec = 49'h1000 + 49'(i);
      checks++; if (os_data !== w(1'b1, 1'b0, rec)) begin errors++; $display("FAIL wrap_tail%0d got %h want %h", i, os_data, w(1'b1, 1'b0, rec)); end
    end
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL wrap_end got cnt=%0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow_and_clr();
    test_empty_pop_write();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
